// File: rtl/cache_pkg.sv
// Shared widths, FSM encodings and requester IDs for the cache/memory arbiter.
package cache_pkg;

  localparam int unsigned ALL_ADDR_LEN = 24;
  localparam int unsigned MEMORY_DW    = 256;
  localparam int unsigned MEMORY_MW    = MEMORY_DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2
  } arb_state_e;

  localparam logic M_ICACHE = 1'b0;
  localparam logic M_DCACHE = 1'b1;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Block-level command/response channel between a cache (master) and memory (slave).
interface cache_mem_arbiter_if
  import cache_pkg::*;
#(
  parameter int unsigned AddrLen = ALL_ADDR_LEN,
  parameter int unsigned DataW   = MEMORY_DW
);

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_read;
  logic [AddrLen-1:0]     cmd_addr;
  logic [DataW-1:0]       cmd_wdata;
  logic [DataW/8-1:0]     cmd_wmask;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DataW-1:0]       rsp_rdata;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/cache_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the one that did not win last.
module cache_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       rr_last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = rr_last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between I-cache (m0) and D-cache (m1), one transaction at a time.
module cache_mem_arbiter
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  cache_mem_arbiter_if.slave  m0,
  cache_mem_arbiter_if.slave  m1,
  cache_mem_arbiter_if.master memory,
  output logic                arb_busy
);

  arb_state_e             state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   rr_last_q, rr_last_d;
  logic                   read_q, read_d;
  logic [ALL_ADDR_LEN-1:0] addr_q, addr_d;
  logic [MEMORY_DW-1:0]   wdata_q, wdata_d;
  logic [MEMORY_MW-1:0]   wmask_q, wmask_d;
  logic [1:0]             gnt;

  cache_rr_arb2 u_rr_arb2 (
    .req_i     ({m1.cmd_valid, m0.cmd_valid}),
    .rr_last_i (rr_last_q),
    .gnt_o     (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= M_ICACHE;
      rr_last_q <= M_DCACHE;
      read_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      read_q    <= read_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    read_d    = read_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    unique case (state_q)
      ST_IDLE: begin
        // Any grant is a handshake: cmd_ready follows the grant combinationally.
        if (|gnt) begin
          state_d   = ST_ISSUE;
          owner_d   = gnt[1];
          rr_last_d = gnt[1];
          read_d    = gnt[1] ? m1.cmd_read  : m0.cmd_read;
          addr_d    = gnt[1] ? m1.cmd_addr  : m0.cmd_addr;
          wdata_d   = gnt[1] ? m1.cmd_wdata : m0.cmd_wdata;
          wmask_d   = gnt[1] ? m1.cmd_wmask : m0.cmd_wmask;
        end
      end
      ST_ISSUE: begin
        if (memory.cmd_ready) begin
          state_d = read_q ? ST_WAIT_RSP : ST_IDLE;
        end
      end
      ST_WAIT_RSP: begin
        if (memory.rsp_valid && memory.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    // Gated by rst_n so readies drop the instant reset asserts, even with requests pending.
    m0.cmd_ready     = rst_n && (state_q == ST_IDLE) && gnt[0];
    m1.cmd_ready     = rst_n && (state_q == ST_IDLE) && gnt[1];
    memory.cmd_valid = (state_q == ST_ISSUE);
    memory.cmd_read  = read_q;
    memory.cmd_addr  = addr_q;
    memory.cmd_wdata = wdata_q;
    memory.cmd_wmask = wmask_q;
    memory.rsp_ready = (state_q == ST_WAIT_RSP) && (owner_q ? m1.rsp_ready : m0.rsp_ready);
    m0.rsp_valid     = (state_q == ST_WAIT_RSP) && (owner_q == M_ICACHE) && memory.rsp_valid;
    m1.rsp_valid     = (state_q == ST_WAIT_RSP) && (owner_q == M_DCACHE) && memory.rsp_valid;
    m0.rsp_rdata     = memory.rsp_rdata;
    m1.rsp_rdata     = memory.rsp_rdata;
    arb_busy         = (state_q != ST_IDLE);
  end

endmodule
